uart_tx_cfg: RTL and testbench

Parametrised UART transmitter, next generation of the team's fixed 8N1 transmitter. Serialises one character per start request. Data width, parity mode, stop-bit count and bit period are compile-time parameters. Keeps the existing tx_start/tx_busy handshake so current benches and call sites port directly; adds a tx_done completion pulse.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 31 +++
 rtl/uart_tx_cfg.sv | 147 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter: parity modes, FSM states, frame sizing.
// The BREAK state exists only when UART_TX_BREAK_EN is defined.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_BREAK_EN
        ,
        BREAK
`endif
    } uart_state_t;

    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned parity_mode,
                                               input int unsigned stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// Held at zero while clear is high, so the first bit after an accept is full width.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_comb begin
        tick = (cnt == TERMINAL);
    end

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter (data width, parity, stop bits, bit period) with tx_start/tx_busy
// handshake and a tx_done pulse. Defining UART_TX_BREAK_EN adds the tx_break line-break input.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_BREAK_EN
    input  logic                 tx_break,
`endif
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    if (PARITY_MODE > PAR_ODD || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
        STOP_BITS > 2 || CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_param_check
        $error("uart_tx_cfg: illegal parameter combination");
    end

    uart_state_t          state;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_q;
    logic                 bit_clear;
    logic                 bit_tick;
`ifdef UART_TX_BREAK_EN
    logic                 brk_q;
`endif

    always_comb begin
        bit_clear = (state == IDLE);
`ifdef UART_TX_BREAK_EN
        bit_clear = bit_clear || (state == BREAK);
`endif
    end

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(bit_clear),
        .tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            par_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
`ifdef UART_TX_BREAK_EN
                    if (tx_break) begin
                        state   <= BREAK;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        brk_q   <= 1'b1;
                    end else
`endif
                    if (tx_start) begin
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        shreg   <= tx_data;
                        bit_idx <= '0;
                        // Parity is fixed at capture, so later tx_data changes cannot affect it.
                        par_q   <= (^tx_data) ^ (PARITY_MODE == PAR_ODD);
                    end
                end
                START: if (bit_tick) begin
                    state   <= DATA;
                    tx      <= shreg[0];
                    shreg   <= shreg >> 1;
                    bit_idx <= '0;
                end
                DATA: if (bit_tick) begin
                    if (bit_idx == LAST_DATA) begin
                        bit_idx <= '0;
                        if (PARITY_MODE != PAR_NONE) begin
                            state <= PARITY;
                            tx    <= par_q;
                        end else begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                PARITY: if (bit_tick) begin
                    state   <= STOP;
                    tx      <= 1'b1;
                    bit_idx <= '0;
                end
                STOP: if (bit_tick) begin
                    if (bit_idx == LAST_STOP) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
`ifdef UART_TX_BREAK_EN
                        tx_done <= ~brk_q;
                        brk_q   <= 1'b0;
`else
                        tx_done <= 1'b1;
`endif
                    end else begin
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
`ifdef UART_TX_BREAK_EN
                // Release reuses the stop phase to guarantee the idle-high recovery time.
                BREAK: if (!tx_break) begin
                    state   <= STOP;
                    tx      <= 1'b1;
                    bit_idx <= '0;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: 8N1, 8E1, 8O1 and 7N2 instances at 16 clocks/bit.
// Break-line checks are compiled in when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start_v;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic [3:0] tx_v, busy_v, done_v;
    logic       brk;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    uart_tx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_start(start_v[0]), .tx_data(d0),
`ifdef UART_TX_BREAK_EN
        .tx_break(brk),
`endif
        .tx(tx_v[0]), .tx_busy(busy_v[0]), .tx_done(done_v[0]));

    uart_tx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_start(start_v[1]), .tx_data(d1),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx(tx_v[1]), .tx_busy(busy_v[1]), .tx_done(done_v[1]));

    uart_tx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_start(start_v[2]), .tx_data(d2),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx(tx_v[2]), .tx_busy(busy_v[2]), .tx_done(done_v[2]));

    uart_tx_cfg #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .tx_start(start_v[3]), .tx_data(d3),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx(tx_v[3]), .tx_busy(busy_v[3]), .tx_done(done_v[3]));

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_data(input logic [1:0] k, input logic [8:0] d);
        case (k)
            2'd0: d0 = d[7:0];
            2'd1: d1 = d[7:0];
            2'd2: d2 = d[7:0];
            default: d3 = d[6:0];
        endcase
    endtask

    task automatic pick(input logic [1:0] k, output logic t, output logic b, output logic dn);
        t  = tx_v[k];
        b  = busy_v[k];
        dn = done_v[k];
    endtask

    // frame: transmitted bits, bit 0 first (start, data LSB first, parity, stops).
    task automatic send_frame(input logic [1:0] k, input logic [8:0] d, input logic [11:0] frame,
                              input int nbits, input int ncyc, input bit keep);
        logic [11:0] fr;
        logic        t, b, dn;
        int          total;
        total = nbits * 16;
        fr = frame;
        set_data(k, d);
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        if (!keep) start_v[k] = 1'b0;
        set_data(k, ~d);
        for (int c = 0; c < total && c < ncyc; c++) begin
            pick(k, t, b, dn);
            chk("frame_tx", {3'b0, t}, {3'b0, fr[0]});
            chk("frame_busy", {3'b0, b}, 4'd1);
            chk("frame_done", {3'b0, dn}, 4'd0);
            if (c % 16 == 15) fr = fr >> 1;
            @(posedge clk); #1;
        end
        if (ncyc >= total) begin
            pick(k, t, b, dn);
            chk("end_tx", {3'b0, t}, 4'd1);
            chk("end_busy", {3'b0, b}, 4'd0);
            chk("end_done", {3'b0, dn}, 4'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        start_v = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        brk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", tx_v, 4'hF);
        chk("rst_busy", busy_v, 4'h0);
        chk("rst_done", done_v, 4'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 8N1 0x9F: 0,1,1,1,1,1,0,0,1,1
        send_frame(2'd0, 9'h09F, 12'h33E, 10, 1000, 1'b0);
        @(posedge clk); #1;
        chk("done_pulse_width", done_v, 4'h0);
        chk("idle_busy", busy_v, 4'h0);

        // 0x3C has four ones: even parity 0, odd parity 1
        send_frame(2'd1, 9'h03C, 12'h478, 11, 1000, 1'b0);
        send_frame(2'd2, 9'h03C, 12'h678, 11, 1000, 1'b0);

        // 7N2 0x55: 7 data bits then two stop bits
        send_frame(2'd3, 9'h055, 12'h3AA, 10, 1000, 1'b0);

        // back-to-back with tx_start held: one idle cycle, second frame carries 0x3C
        @(posedge clk); #1;
        send_frame(2'd0, 9'h09F, 12'h33E, 10, 1000, 1'b1);
        send_frame(2'd0, 9'h03C, 12'h278, 10, 1000, 1'b0);

        // reset 50 cycles into a frame
        @(posedge clk); #1;
        send_frame(2'd0, 9'h09F, 12'h33E, 10, 50, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx", {3'b0, tx_v[0]}, 4'd1);
        chk("midrst_busy", {3'b0, busy_v[0]}, 4'd0);
        chk("midrst_done", {3'b0, done_v[0]}, 4'd0);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("postrst_idle", {busy_v[0], done_v[0]}, 4'd0);
        end
        send_frame(2'd0, 9'h03C, 12'h278, 10, 1000, 1'b0);

`ifdef UART_TX_BREAK_EN
        @(posedge clk); #1;
        brk = 1'b1;
        start_v[0] = 1'b1;
        d0 = 8'hA5;
        @(posedge clk); #1;
        for (int c = 0; c < 100; c++) begin
            chk("brk_tx", {3'b0, tx_v[0]}, 4'd0);
            chk("brk_busy", {busy_v[0], done_v[0]}, 4'd2);
            if (c == 99) begin
                brk = 1'b0;
                start_v[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 16; c++) begin
            chk("brk_stop_tx", {3'b0, tx_v[0]}, 4'd1);
            chk("brk_stop_busy", {busy_v[0], done_v[0]}, 4'd2);
            @(posedge clk); #1;
        end
        chk("brk_end", {tx_v[0], busy_v[0], done_v[0]}, 4'd4);
        @(posedge clk); #1;
        chk("brk_idle", {tx_v[0], busy_v[0], done_v[0]}, 4'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
